vga_text_writer: RTL and testbench
==================================

Name: vga_text_writer

Overview:
- Write-side engine for the VGA text-mode character buffer that the pixel generator scans.
- Accepts a byte stream of ASCII characters and control codes over a valid/ready handshake, maintains a cursor, and emits 16-bit character/attribute words to the text RAM write port.
- Handles line wrap, CR/LF/BS, form-feed clear, and hardware scroll by copying rows through the RAM read port.

Parameters:
COLS, 80, characters per row
ROWS, 30, character rows (640x480, 8x16 cells)
BASE_ADDR, 0, RAM word address of cell (0,0); cell address = BASE_ADDR + row*COLS + col

Ports:
pixel_clk  in  1  single clock for writer and RAM port
data_reset_n  in  1  asynchronous, active-low reset
char_valid  in  1  byte available
char_data  in  8  ASCII byte or control code
char_fg  in  3  foreground RGB, sampled with byte
char_bg  in  3  background RGB, sampled with byte
char_ready  out  1  writer can accept byte this cycle
mem_we  out  1  RAM write strobe
mem_addr  out  16  RAM word address (read or write)
mem_wdata  out  16  {1'b0, bg[2:0], 1'b0, fg[2:0], ascii[7:0]}
mem_rdata  in  16  RAM read data, valid 1 cycle after mem_addr
cursor_col  out  7  current column 0..COLS-1
cursor_row  out  5  current row 0..ROWS-1
busy  out  1  scroll or clear in progress

Behaviour:
- Reset (async, data_reset_n=0): state IDLE; cursor 0,0; mem_we=0; mem_addr=0; mem_wdata=0; busy=0; char_ready=0. char_ready rises the first cycle after deassertion.
- All outputs registered. Byte accepted on the edge where char_valid && char_ready. char_ready = (state==IDLE) && reset released.
- Attribute (fg,bg) captured at acceptance; used for the printed cell or for all blank cells of a clear or scroll.
- Blank word = {0,bg,0,fg,8'h20}.
- Printable byte 0x20..0x7E: next cycle mem_we=1, addr=cursor cell, wdata=word; col++. Throughput 1 byte/cycle.
- Wrap: if col was COLS-1, col=0 and row++.
- Last row: if row was ROWS-1, row stays ROWS-1 and the writer enters SCROLL after the write.
- 0x0D CR: col=0, no write.
- 0x0A LF: row++ with no column change. At ROWS-1, enter SCROLL instead.
- 0x08 BS: col-- if col>0, else no-op. No write, no row change.
- 0x0C FF: enter CLEAR; cursor 0,0.
- Any other byte: consumed, ignored.
- SCROLL:
  - Copy cell i+COLS to cell i for i = 0..(ROWS-1)*COLS-1.
  - Per cell, SCR_RD presents the read addr with mem_we=0; the next cycle SCR_WR writes mem_rdata to addr i.
  - 2 cycles/cell, then SCR_CLR writes blank to the COLS cells of the last row, 1/cycle, then IDLE.
  - Total (ROWS-1)*COLS*2 + COLS cycles = 4720 at defaults.
- CLEAR: writes blank to all ROWS*COLS cells, 1/cycle ascending from BASE_ADDR (2400 cycles), then IDLE.
- busy=1 for exactly the cycles spent in SCR_RD/SCR_WR/SCR_CLR/CLEAR. char_ready=0 throughout.
- mem_we is never asserted in IDLE except the single printable-write cycle.
- Address arithmetic is 16-bit unsigned. A single incrementing index is used, with no per-cycle multiply.
- Reset mid-scroll/clear: immediate abort to IDLE, cursor 0,0. RAM contents are left partial; no repair.
- char_valid held while not ready: the byte is not consumed and is accepted on the first ready cycle.

Test Plan:
- Reset, then bytes 'H','i' with fg=3'b111, bg=3'b001 -> writes addr 0 data 16'h1748, addr 1 data 16'h1769; cursor 2,0; char_ready high throughout.
- Cursor at col 79 row 2, byte 'A' fg=7 bg=0 -> write addr 239 data 16'h0741, cursor 0,3, no scroll.
- 0x0D then 0x08 at col 0 then 0x0A at row 5 -> no mem_we; cursor 0,6.
- Preload RAM row r with value r; LF at row 29 -> busy high for 4720 cycles. Rows 0..28 then hold r+1, row 29 = blank; cursor row 29; char_ready low during busy.
- 0x0C with bg=3'b100 fg=0 -> 2400 writes of 16'h4020 to addrs 0..2399; cursor 0,0; busy then low.
- Assert data_reset_n=0 at cycle 100 of a CLEAR -> mem_we drops same edge. After release, cursor 0,0 and next byte 'Z' writes addr 0.

Source files
------------

// File: rtl/vga_text_writer.sv
// vga_text_writer: byte-stream text writer with cursor, wrap, control codes, clear and hardware scroll
module vga_text_writer #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 30,
  parameter logic [15:0] BASE_ADDR = 16'd0
) (
  input  logic        pixel_clk,
  input  logic        data_reset_n,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  input  logic [2:0]  char_fg,
  input  logic [2:0]  char_bg,
  output logic        char_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, SCR_RD, SCR_WR, SCR_CLR, CLEAR} state_t;
  localparam logic [15:0] NCOLS   = 16'(COLS);
  localparam logic [15:0] LAST_CP = 16'((ROWS - 1) * COLS - 1);
  localparam logic [15:0] LAST    = 16'(ROWS * COLS - 1);
  localparam logic [6:0]  LCOL    = 7'(COLS - 1);
  localparam logic [4:0]  LROW    = 5'(ROWS - 1);
  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d, cell_q, cell_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [5:0]  attr_q, attr_d;
  logic        pend_q, pend_d, we_q, we_d, busy_q, busy_d, ready_q, ready_d;
  logic        acc, prn, wrap, blank;
  always_comb begin
    acc     = char_valid && ready_q;
    prn     = acc && char_data >= 8'h20 && char_data <= 8'h7E;
    wrap    = col_q == LCOL;
    state_d = state_q;
    idx_d   = idx_q;
    cell_d  = cell_q;
    col_d   = col_q;
    row_d   = row_q;
    pend_d  = 1'b0;
    attr_d  = acc ? {char_bg, char_fg} : attr_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = SCR_RD;
          idx_d   = 16'd0;
        end else if (prn) begin
          // cell_q tracks row*COLS+col incrementally so no multiplier is needed
          cell_d = (wrap && row_q == LROW) ? LAST_CP + 16'd1 : cell_q + 16'd1;
          col_d  = wrap ? 7'd0 : col_q + 7'd1;
          row_d  = (wrap && row_q != LROW) ? row_q + 5'd1 : row_q;
          pend_d = wrap && row_q == LROW;
        end else if (acc && char_data == 8'h0D) begin
          col_d  = 7'd0;
          cell_d = cell_q - 16'(col_q);
        end else if (acc && char_data == 8'h0A) begin
          state_d = row_q == LROW ? SCR_RD : IDLE;
          idx_d   = 16'd0;
          row_d   = row_q == LROW ? row_q : row_q + 5'd1;
          cell_d  = row_q == LROW ? cell_q : cell_q + NCOLS;
        end else if (acc && char_data == 8'h08 && col_q != 7'd0) begin
          col_d  = col_q - 7'd1;
          cell_d = cell_q - 16'd1;
        end else if (acc && char_data == 8'h0C) begin
          state_d = CLEAR;
          idx_d   = 16'd0;
          col_d   = 7'd0;
          row_d   = 5'd0;
          cell_d  = 16'd0;
        end
      end
      SCR_RD: state_d = SCR_WR;
      SCR_WR: begin
        idx_d   = idx_q + 16'd1;
        state_d = idx_q == LAST_CP ? SCR_CLR : SCR_RD;
      end
      SCR_CLR, CLEAR: begin
        idx_d   = idx_q + 16'd1;
        state_d = idx_q == LAST ? IDLE : state_q;
      end
      default: state_d = IDLE;
    endcase
    blank   = state_d == SCR_CLR || state_d == CLEAR;
    we_d    = prn || blank || state_d == SCR_WR;
    addr_d  = prn ? BASE_ADDR + cell_q :
              state_d == SCR_RD ? BASE_ADDR + idx_d + NCOLS :
              state_d == IDLE ? addr_q : BASE_ADDR + idx_d;
    wdata_d = prn ? {1'b0, char_bg, 1'b0, char_fg, char_data} :
              blank ? {1'b0, attr_d[5:3], 1'b0, attr_d[2:0], 8'h20} : wdata_q;
    busy_d  = state_d != IDLE;
    ready_d = state_d == IDLE && !pend_d;
  end
  always_ff @(posedge pixel_clk or negedge data_reset_n) begin
    if (!data_reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cell_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      attr_q  <= '0;
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cell_q  <= cell_d;
      col_q   <= col_d;
      row_q   <= row_d;
      attr_q  <= attr_d;
      pend_q  <= pend_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end
  // read data only arrives in the copy-write cycle, so it bypasses the data register
  assign mem_wdata  = state_q == SCR_WR ? mem_rdata : wdata_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign busy       = busy_q;
  assign char_ready = ready_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
endmodule

// File: tb/tb_vga_text_writer.sv
// tb_vga_text_writer: directed vectors plus scroll/clear/reset sequences against a bench RAM
module tb_vga_text_writer;
  logic        pixel_clk = 1'b0, data_reset_n, char_valid;
  logic [7:0]  char_data;
  logic [2:0]  char_fg, char_bg;
  logic        char_ready, mem_we, busy, preload;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [15:0] ram [0:4095];
  int          n_vec = 0, n_bad = 0;

  vga_text_writer dut (
    .pixel_clk(pixel_clk), .data_reset_n(data_reset_n), .char_valid(char_valid),
    .char_data(char_data), .char_fg(char_fg), .char_bg(char_bg), .char_ready(char_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) begin
    if (preload) begin
      for (int i = 0; i < 2400; i++) ram[i] <= 16'(i / 80);
    end else if (mem_we) begin
      ram[mem_addr[11:0]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[11:0]];
  end

  typedef struct {
    logic [7:0]  d;
    logic [2:0]  f, b;
    int          rep;
    logic        we;
    logic [15:0] a, w;
    logic [6:0]  c;
    logic [4:0]  r;
  } vec_t;
  vec_t tv [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [7:0] d, input logic [2:0] f, input logic [2:0] b);
    @(negedge pixel_clk);
    char_valid = 1'b1;
    char_data  = d;
    char_fg    = f;
    char_bg    = b;
    @(posedge pixel_clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic run_busy(output int cyc, output int rdy_hi, output int clr_bad);
    cyc = 0;
    rdy_hi = 0;
    clr_bad = 0;
    while (busy && cyc < 20000) begin
      if (char_ready) rdy_hi++;
      if (!(mem_we && mem_addr == 16'(cyc) && mem_wdata == 16'h4020)) clr_bad++;
      cyc++;
      @(posedge pixel_clk);
      #1;
    end
  endtask

  initial begin
    int cyc, rdy_hi, clr_bad, bad;
    tv[0]  = '{8'h48, 3'd7, 3'd1, 1,  1'b1, 16'd0,   16'h1748, 7'd1,  5'd0};
    tv[1]  = '{8'h69, 3'd7, 3'd1, 1,  1'b1, 16'd1,   16'h1769, 7'd2,  5'd0};
    tv[2]  = '{8'h0D, 3'd0, 3'd0, 1,  1'b0, 16'd0,   16'h0000, 7'd0,  5'd0};
    tv[3]  = '{8'h08, 3'd0, 3'd0, 1,  1'b0, 16'd0,   16'h0000, 7'd0,  5'd0};
    tv[4]  = '{8'h0A, 3'd0, 3'd0, 1,  1'b0, 16'd0,   16'h0000, 7'd0,  5'd1};
    tv[5]  = '{8'h0A, 3'd0, 3'd0, 1,  1'b0, 16'd0,   16'h0000, 7'd0,  5'd2};
    tv[6]  = '{8'h01, 3'd0, 3'd0, 1,  1'b0, 16'd0,   16'h0000, 7'd0,  5'd2};
    tv[7]  = '{8'h78, 3'd7, 3'd0, 79, 1'b1, 16'd238, 16'h0778, 7'd79, 5'd2};
    tv[8]  = '{8'h41, 3'd7, 3'd0, 1,  1'b1, 16'd239, 16'h0741, 7'd0,  5'd3};
    tv[9]  = '{8'h0A, 3'd0, 3'd0, 2,  1'b0, 16'd0,   16'h0000, 7'd0,  5'd5};
    tv[10] = '{8'h0D, 3'd0, 3'd0, 1,  1'b0, 16'd0,   16'h0000, 7'd0,  5'd5};
    tv[11] = '{8'h08, 3'd0, 3'd0, 1,  1'b0, 16'd0,   16'h0000, 7'd0,  5'd5};
    tv[12] = '{8'h0A, 3'd0, 3'd0, 1,  1'b0, 16'd0,   16'h0000, 7'd0,  5'd6};
    tv[13] = '{8'h62, 3'd2, 3'd3, 1,  1'b1, 16'd480, 16'h3262, 7'd1,  5'd6};
    tv[14] = '{8'h08, 3'd0, 3'd0, 1,  1'b0, 16'd0,   16'h0000, 7'd0,  5'd6};
    tv[15] = '{8'h63, 3'd2, 3'd3, 1,  1'b1, 16'd480, 16'h3263, 7'd1,  5'd6};
    tv[16] = '{8'h0D, 3'd0, 3'd0, 1,  1'b0, 16'd0,   16'h0000, 7'd0,  5'd6};

    data_reset_n = 1'b0;
    char_valid = 1'b0;
    char_data = 8'h00;
    char_fg = 3'd0;
    char_bg = 3'd0;
    preload = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", char_ready, 0);
    chk("rst_cursor", {cursor_row, cursor_col}, 0);
    @(negedge pixel_clk);
    data_reset_n = 1'b1;
    @(posedge pixel_clk);
    #1;
    chk("ready_after_rst", char_ready, 1);

    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < tv[i].rep; k++) apply(tv[i].d, tv[i].f, tv[i].b);
      chk($sformatf("v%0d_we", i), mem_we, tv[i].we);
      if (tv[i].we) begin
        chk($sformatf("v%0d_addr", i), mem_addr, tv[i].a);
        chk($sformatf("v%0d_wdata", i), mem_wdata, tv[i].w);
      end
      chk($sformatf("v%0d_col", i), cursor_col, tv[i].c);
      chk($sformatf("v%0d_row", i), cursor_row, tv[i].r);
      chk($sformatf("v%0d_ready", i), char_ready, 1);
    end

    // LF on the last row scrolls a preloaded screen
    @(negedge pixel_clk);
    preload = 1'b1;
    @(posedge pixel_clk);
    #1;
    preload = 1'b0;
    repeat (23) apply(8'h0A, 3'd0, 3'd0);
    chk("row29", cursor_row, 29);
    apply(8'h0A, 3'd5, 3'd2);
    chk("lf_scroll_busy", busy, 1);
    run_busy(cyc, rdy_hi, clr_bad);
    chk("lf_scroll_cycles", cyc, 4720);
    chk("lf_scroll_ready_low", rdy_hi, 0);
    bad = 0;
    for (int i = 0; i < 2320; i++) if (ram[i] !== 16'(i / 80 + 1)) bad++;
    for (int i = 2320; i < 2400; i++) if (ram[i] !== 16'h2520) bad++;
    chk("lf_scroll_ram_bad", bad, 0);
    chk("lf_scroll_cursor", {cursor_row, cursor_col}, {5'd29, 7'd0});

    // print wrap at the last cell, then a byte held while busy
    repeat (79) apply(8'h77, 3'd7, 3'd0);
    apply(8'h57, 3'd7, 3'd0);
    chk("wrap_we", mem_we, 1);
    chk("wrap_addr", mem_addr, 2399);
    chk("wrap_wdata", mem_wdata, 16'h0757);
    chk("wrap_busy", busy, 0);
    chk("wrap_ready", char_ready, 0);
    chk("wrap_cursor", {cursor_row, cursor_col}, {5'd29, 7'd0});
    @(negedge pixel_clk);
    char_valid = 1'b1;
    char_data = 8'h51;
    char_fg = 3'd1;
    char_bg = 3'd0;
    @(posedge pixel_clk);
    #1;
    run_busy(cyc, rdy_hi, clr_bad);
    chk("wrap_scroll_cycles", cyc, 4720);
    chk("wrap_scroll_ready_low", rdy_hi, 0);
    @(posedge pixel_clk);
    #1;
    char_valid = 1'b0;
    chk("held_we", mem_we, 1);
    chk("held_addr", mem_addr, 2320);
    chk("held_wdata", mem_wdata, 16'h0151);
    chk("held_col", cursor_col, 1);
    chk("ram_2319", ram[2319], 16'h0757);
    chk("ram_2240", ram[2240], 16'h0777);

    // form feed clear
    apply(8'h0C, 3'd0, 3'd4);
    chk("ff_cursor", {cursor_row, cursor_col}, 0);
    run_busy(cyc, rdy_hi, clr_bad);
    chk("ff_cycles", cyc, 2400);
    chk("ff_write_bad", clr_bad, 0);
    chk("ff_ready_low", rdy_hi, 0);
    chk("ff_busy_end", busy, 0);
    @(posedge pixel_clk);
    #1;
    chk("ff_ram_1234", ram[1234], 16'h4020);
    chk("ff_ram_2399", ram[2399], 16'h4020);

    // reset in the middle of a clear
    apply(8'h0C, 3'd0, 3'd4);
    repeat (99) @(posedge pixel_clk);
    #2;
    chk("mid_we_before", mem_we, 1);
    data_reset_n = 1'b0;
    #1;
    chk("abort_we", mem_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", char_ready, 0);
    @(negedge pixel_clk);
    data_reset_n = 1'b1;
    @(posedge pixel_clk);
    #1;
    chk("abort_ready_up", char_ready, 1);
    chk("abort_cursor", {cursor_row, cursor_col}, 0);
    apply(8'h5A, 3'd7, 3'd1);
    chk("z_we", mem_we, 1);
    chk("z_addr", mem_addr, 0);
    chk("z_wdata", mem_wdata, 16'h175A);
    chk("z_col", cursor_col, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
